// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared types and default timing for the PWM control front end
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAILSAFE = 2'd3
  } state_t;

  localparam logic [1:0] CH_SERVO0 = 2'd0;
  localparam logic [1:0] CH_ESC    = 2'd1;
  localparam logic [1:0] CH_SERVO2 = 2'd2;

  localparam int SERVO_W = 19;
  localparam int ESC_W   = 17;

  localparam int DEF_SERVO_MIN    = 12000;
  localparam int DEF_SERVO_MAX    = 24000;
  localparam int DEF_SERVO_CENTER = 18000;
  localparam int DEF_ESC_MIN      = 12000;
  localparam int DEF_ESC_MAX      = 22000;
  localparam int DEF_ESC_SLEW     = 600;
  localparam int DEF_ARM_FRAMES   = 1000;
  localparam int DEF_WDOG_FRAMES  = 250;

  function automatic logic [SERVO_W-1:0] clamp_width(
    input logic [SERVO_W-1:0] v,
    input logic [SERVO_W-1:0] lo,
    input logic [SERVO_W-1:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/esc_slew_limiter.sv
// rtl/esc_slew_limiter.sv - one-frame step of the ESC duty toward its target, never overshooting
module esc_slew_limiter
  import pwm_ctrl_pkg::*;
(
  input  logic [ESC_W-1:0] i_current,
  input  logic [ESC_W-1:0] i_target,
  input  logic [ESC_W-1:0] i_step,
  input  logic             i_enable,
  output logic [ESC_W-1:0] o_next
);

  logic [ESC_W-1:0] w_up_diff;
  logic [ESC_W-1:0] w_dn_diff;

  // Differences are always larger-minus-smaller, so they cannot wrap.
  assign w_up_diff = i_target - i_current;
  assign w_dn_diff = i_current - i_target;

  always_comb begin
    o_next = i_current;
    if (i_enable) begin
      if (i_target > i_current)
        o_next = (w_up_diff > i_step) ? i_current + i_step : i_target;
      else if (i_target < i_current)
        o_next = (w_dn_diff > i_step) ? i_current - i_step : i_target;
    end
  end

endmodule

// File: rtl/pwm_throttle_sequencer.sv
// rtl/pwm_throttle_sequencer.sv - command intake, frame-aligned duty apply, ESC arming and watchdog
module pwm_throttle_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int SERVO_MIN    = DEF_SERVO_MIN,
  parameter int SERVO_MAX    = DEF_SERVO_MAX,
  parameter int SERVO_CENTER = DEF_SERVO_CENTER,
  parameter int ESC_MIN      = DEF_ESC_MIN,
  parameter int ESC_MAX      = DEF_ESC_MAX,
  parameter int ESC_SLEW     = DEF_ESC_SLEW,
  parameter int ARM_FRAMES   = DEF_ARM_FRAMES,
  parameter int WDOG_FRAMES  = DEF_WDOG_FRAMES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_chan,
  input  logic [SERVO_W-1:0] cmd_value,
  input  logic               arm_req,
  input  logic               disarm_req,
  input  logic               esc_frame_tick,
  input  logic               servo_frame_tick,
  output logic [SERVO_W-1:0] duty0_out,
  output logic [ESC_W-1:0]   duty1_out,
  output logic [SERVO_W-1:0] duty2_out,
  output logic               armed,
  output logic               failsafe
);

  localparam int ARM_W = $clog2(ARM_FRAMES + 1);
  localparam int WD_W  = $clog2(WDOG_FRAMES + 1);
  localparam logic [SERVO_W-1:0] SRV_CTR = SERVO_W'(SERVO_CENTER);
  localparam logic [ESC_W-1:0]   ESC_LO  = ESC_W'(ESC_MIN);

  state_t             r_state;
  logic [SERVO_W-1:0] r_tgt0, r_tgt2, r_duty0, r_duty2;
  logic [ESC_W-1:0]   r_tgt1, r_duty1;
  logic [ARM_W-1:0]   r_arm_cnt;
  logic [WD_W-1:0]    r_wd_cnt;

  logic               w_acc, w_feed, w_wd_expire;
  logic [SERVO_W-1:0] w_servo_val, w_esc_clamped;
  logic [ESC_W-1:0]   w_esc_val, w_duty1_next;

  assign cmd_ready     = ~rst;
  assign w_acc         = cmd_valid & cmd_ready;
  assign w_feed        = w_acc && (cmd_chan != 2'd3);
  assign w_servo_val   = clamp_width(cmd_value, SERVO_W'(SERVO_MIN), SERVO_W'(SERVO_MAX));
  assign w_esc_clamped = clamp_width(cmd_value, SERVO_W'(ESC_MIN), SERVO_W'(ESC_MAX));
  assign w_esc_val     = ESC_W'(w_esc_clamped);
  assign w_wd_expire   = esc_frame_tick && (r_wd_cnt == WD_W'(WDOG_FRAMES - 1));

  esc_slew_limiter u_slew (
    .i_current (r_duty1),
    .i_target  (r_tgt1),
    .i_step    (ESC_W'(ESC_SLEW)),
    .i_enable  (esc_frame_tick),
    .o_next    (w_duty1_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DISARMED;
      r_tgt0    <= SRV_CTR;
      r_tgt2    <= SRV_CTR;
      r_tgt1    <= ESC_LO;
      r_duty0   <= SRV_CTR;
      r_duty2   <= SRV_CTR;
      r_duty1   <= ESC_LO;
      r_arm_cnt <= '0;
      r_wd_cnt  <= '0;
    end else begin
      if (w_acc && cmd_chan == CH_SERVO0) r_tgt0 <= w_servo_val;
      if (w_acc && cmd_chan == CH_SERVO2) r_tgt2 <= w_servo_val;
      if (w_acc && cmd_chan == CH_ESC && r_state == ARMED) r_tgt1 <= w_esc_val;
      // Shadows are sampled before this cycle's command lands, so a tick-cycle command waits a frame.
      if (servo_frame_tick) begin
        r_duty0 <= r_tgt0;
        r_duty2 <= r_tgt2;
      end
      case (r_state)
        DISARMED: begin
          r_duty1 <= ESC_LO;
          if (arm_req) begin
            r_state   <= ARMING;
            r_arm_cnt <= '0;
          end
        end
        ARMING: begin
          r_duty1 <= ESC_LO;
          if (esc_frame_tick) begin
            if (r_arm_cnt == ARM_W'(ARM_FRAMES - 1)) begin
              r_state  <= ARMED;
              r_tgt1   <= ESC_LO;
              r_wd_cnt <= '0;
            end else begin
              r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end
          end
        end
        ARMED: begin
          r_duty1 <= w_duty1_next;
          if (w_wd_expire)         r_state  <= FAILSAFE;
          else if (w_feed)         r_wd_cnt <= '0;
          else if (esc_frame_tick) r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
        FAILSAFE: begin
          r_duty1 <= ESC_LO;
          r_tgt1  <= ESC_LO;
          r_duty0 <= SRV_CTR;
          r_duty2 <= SRV_CTR;
          r_tgt0  <= SRV_CTR;
          r_tgt2  <= SRV_CTR;
        end
        default: r_state <= DISARMED;
      endcase
      // Disarm overrides arm requests and watchdog expiry; servo targets are left alone.
      if (disarm_req) begin
        r_state   <= DISARMED;
        r_duty1   <= ESC_LO;
        r_tgt1    <= ESC_LO;
        r_arm_cnt <= '0;
        r_wd_cnt  <= '0;
      end
    end
  end

  assign duty0_out = r_duty0;
  assign duty1_out = r_duty1;
  assign duty2_out = r_duty2;
  assign armed     = (r_state == ARMED);
  assign failsafe  = (r_state == FAILSAFE);

endmodule

// File: tb/tb_pwm_throttle_sequencer.sv
// tb/tb_pwm_throttle_sequencer.sv - directed checks of clamping, frame alignment, arming, slew and watchdog
module tb_pwm_throttle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_chan;
  logic [18:0] cmd_value;
  logic        arm_req;
  logic        disarm_req;
  logic        esc_frame_tick;
  logic        servo_frame_tick;
  logic [18:0] duty0_out;
  logic [16:0] duty1_out;
  logic [18:0] duty2_out;
  logic        armed;
  logic        failsafe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_throttle_sequencer #(.ARM_FRAMES(4), .WDOG_FRAMES(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_chan         (cmd_chan),
    .cmd_value        (cmd_value),
    .arm_req          (arm_req),
    .disarm_req       (disarm_req),
    .esc_frame_tick   (esc_frame_tick),
    .servo_frame_tick (servo_frame_tick),
    .duty0_out        (duty0_out),
    .duty1_out        (duty1_out),
    .duty2_out        (duty2_out),
    .armed            (armed),
    .failsafe         (failsafe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [18:0] val);
    cmd_valid = 1'b1; cmd_chan = ch; cmd_value = val;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic esc_tick();
    esc_frame_tick = 1'b1;
    step();
    esc_frame_tick = 1'b0;
  endtask

  task automatic servo_tick();
    servo_frame_tick = 1'b1;
    step();
    servo_frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    check("ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    step();
  endtask

  task automatic arm_sequence();
    arm_req = 1'b1; step(); arm_req = 1'b0;
    for (int i = 0; i < 4; i++) esc_tick();
  endtask

  int exp_ramp[5] = '{12600, 13200, 13800, 14400, 15000};

  initial begin
    cmd_valid = 0; cmd_chan = 0; cmd_value = 0; arm_req = 0; disarm_req = 0;
    esc_frame_tick = 0; servo_frame_tick = 0; rst = 1;

    do_reset();
    check("rst_ready", cmd_ready, 1);
    check("rst_duty0", duty0_out, 18000);
    check("rst_duty1", duty1_out, 12000);
    check("rst_duty2", duty2_out, 18000);
    check("rst_armed", armed, 0);
    check("rst_failsafe", failsafe, 0);
    for (int i = 0; i < 5; i++) servo_tick();
    check("idle_duty0", duty0_out, 18000);
    check("idle_duty2", duty2_out, 18000);
    check("idle_duty1", duty1_out, 12000);

    // Clamping and tick alignment
    send(2'd0, 19'd30000);
    send(2'd2, 19'd5000);
    step();
    check("pre_tick_duty0", duty0_out, 18000);
    check("pre_tick_duty2", duty2_out, 18000);
    servo_tick();
    check("clamp_hi_duty0", duty0_out, 24000);
    check("clamp_lo_duty2", duty2_out, 12000);
    servo_frame_tick = 1'b1;
    send(2'd0, 19'd20000);
    servo_frame_tick = 1'b0;
    check("tickcycle_cmd_deferred", duty0_out, 24000);
    servo_tick();
    check("tickcycle_cmd_applied", duty0_out, 20000);

    // Disarm beats arm in the same cycle
    arm_req = 1'b1; disarm_req = 1'b1; step();
    arm_req = 1'b0; disarm_req = 1'b0;
    for (int i = 0; i < 5; i++) esc_tick();
    check("arm_disarm_prio", armed, 0);

    // ESC command while disarmed is dropped; then arm
    send(2'd1, 19'd20000);
    arm_req = 1'b1; step(); arm_req = 1'b0;
    for (int i = 0; i < 3; i++) esc_tick();
    check("arming_3_ticks", armed, 0);
    check("arming_duty1", duty1_out, 12000);
    esc_tick();
    check("armed_after_4", armed, 1);
    check("armed_duty1", duty1_out, 12000);
    esc_tick();
    check("disarmed_cmd_dropped", duty1_out, 12000);

    // Slew ramp, re-sending the command to keep the watchdog fed
    for (int i = 0; i < 5; i++) begin
      send(2'd1, 19'd15000);
      esc_tick();
      check($sformatf("ramp_%0d", i), duty1_out, 17'(exp_ramp[i]));
    end
    send(2'd1, 19'd15000);
    esc_tick();
    check("ramp_hold", duty1_out, 15000);
    send(2'd1, 19'd14700);
    esc_tick();
    check("ramp_exact_down", duty1_out, 14700);
    send(2'd1, 19'd15000);
    esc_tick();
    check("ramp_back", duty1_out, 15000);

    // Watchdog: third silent tick expires even with a command in that cycle
    send(2'd0, 19'd20000);
    esc_tick();
    esc_tick();
    check("wd_not_yet", failsafe, 0);
    esc_frame_tick = 1'b1;
    send(2'd0, 19'd21000);
    esc_frame_tick = 1'b0;
    check("wd_expire", failsafe, 1);
    step();
    check("fs_duty1", duty1_out, 12000);
    check("fs_duty0", duty0_out, 18000);
    check("fs_duty2", duty2_out, 18000);
    servo_tick();
    check("fs_shadow0", duty0_out, 18000);
    arm_req = 1'b1; step(); arm_req = 1'b0;
    check("fs_arm_ignored", failsafe, 1);
    check("fs_not_armed", armed, 0);
    disarm_req = 1'b1; step(); disarm_req = 1'b0;
    check("fs_disarm", failsafe, 0);
    check("fs_disarm_duty1", duty1_out, 12000);

    // Reset mid-ramp
    arm_sequence();
    check("rearmed", armed, 1);
    send(2'd1, 19'd20000);
    esc_tick();
    check("rearm_ramp", duty1_out, 12600);
    do_reset();
    check("midramp_rst_duty1", duty1_out, 12000);
    check("midramp_rst_armed", armed, 0);
    check("midramp_rst_duty0", duty0_out, 18000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_throttle_sequencer.md
Name: pwm_throttle_sequencer

Overview:
Control-plane front end for the 3-channel PWM generator (servo0 and servo2 at 50 Hz, ESC at 500 Hz, 12 MHz clk).
- Accepts pulse-width commands over a valid/ready interface and clamps them to safe ranges.
- Applies new widths only at PWM period boundaries, so no runt or stretched pulses occur.
- Runs the ESC arm/disarm sequence, slew-limits throttle, and forces failsafe on command loss.
- Outputs drive the generator's duty-compare registers directly.

Parameters:
- SERVO_MIN, 12000: minimum servo pulse, clk counts (1.0 ms).
- SERVO_MAX, 24000: maximum servo pulse (2.0 ms).
- SERVO_CENTER, 18000: servo reset/failsafe pulse (1.5 ms).
- ESC_MIN, 12000: ESC idle/disarmed pulse.
- ESC_MAX, 22000: ESC full-throttle pulse.
- ESC_SLEW, 600: maximum ESC duty change per ESC frame.
- ARM_FRAMES, 1000: ESC frames held at ESC_MIN before ARMED (2 s).
- WDOG_FRAMES, 250: ESC frames without a command before FAILSAFE (0.5 s).

Ports:
- clk  in  1  12 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid & ready.
- cmd_chan  in  2  0=servo0, 1=ESC, 2=servo2, 3=reserved.
- cmd_value  in  19  requested pulse width, clk counts.
- arm_req  in  1  single-cycle arm request.
- disarm_req  in  1  single-cycle disarm request.
- esc_frame_tick  in  1  one-cycle pulse at ESC counter wrap (500 Hz).
- servo_frame_tick  in  1  one-cycle pulse at servo counter wrap (50 Hz).
- duty0_out  out  19  servo0 compare value.
- duty1_out  out  17  ESC compare value.
- duty2_out  out  19  servo2 compare value.
- armed  out  1  state == ARMED.
- failsafe  out  1  state == FAILSAFE.

Behaviour:
- Reset, all synchronous:
  - state=DISARMED; duty0_out=duty2_out=SERVO_CENTER; duty1_out=ESC_MIN.
  - Shadow targets = same values; counters=0; cmd_ready=0 during rst, 1 in the first cycle after.
- cmd_ready is 1 in every state, so a command is accepted in one cycle.
  - Value clamped to [MIN,MAX] of its channel and written to that channel's shadow target.
  - chan=3 is accepted and discarded; it does not feed the watchdog.
  - ESC commands are stored only in ARMED; otherwise they are discarded but still feed the watchdog.
- Servo apply: on servo_frame_tick, duty0_out/duty2_out <= shadow targets.
  - Visible 1 cycle after the tick.
  - A command accepted in the tick cycle is applied at the next tick.
- ESC apply, ARMED only: on esc_frame_tick, duty1_out moves toward its target by min(|target-duty1|, ESC_SLEW).
  - Never overshoots; arithmetic is 17-bit unsigned with no wrap.
- States:
  - DISARMED: duty1=ESC_MIN. arm_req -> ARMING, arm_cnt=0.
  - ARMING: duty1=ESC_MIN; arm_cnt increments per esc_frame_tick.
    - When arm_cnt reaches ARM_FRAMES-1 on a tick -> ARMED, with ESC target=ESC_MIN.
  - ARMED: slew active. The watchdog counts esc_frame_ticks and clears on any valid ESC/servo command.
    - When wd_cnt reaches WDOG_FRAMES-1 on a tick -> FAILSAFE.
  - FAILSAFE: in the next cycle, duty1=ESC_MIN and duty0/duty2=SERVO_CENTER, applied immediately without slew or tick.
    - Shadows are also forced to these values.
    - Exit only via disarm_req -> DISARMED. arm_req is ignored.
- disarm_req from any state -> DISARMED with duty1=ESC_MIN next cycle, no slew; servo targets are unchanged.
  - disarm_req has priority over arm_req in the same cycle.
  - It also has priority over a watchdog expiry in the same cycle.
- arm_req outside DISARMED is ignored.
- A command and watchdog expiry in the same cycle: expiry wins (FAILSAFE).
- rst mid-ARMING or mid-ramp returns to reset values; no partial state survives.

Decomposition:
- Package pwm_ctrl_pkg holds:
  - state enum (DISARMED, ARMING, ARMED, FAILSAFE);
  - channel IDs (CH_SERVO0=0, CH_ESC=1, CH_SERVO2=2);
  - width constants (SERVO_W=19, ESC_W=17);
  - default timing constants.
- Sub-module esc_slew_limiter (current, target, step, enable -> next) is purely combinational; the registered duty lives in the parent.

Test Plan:
- Reset then 5 servo ticks, no commands -> duty0=duty2=18000, duty1=12000, armed=0, cmd_ready=1.
- Clamping and tick alignment:
  - Send servo0=30000, then servo2=5000 -> shadows 24000/12000.
  - Outputs stay at 18000 until the next servo_frame_tick, then change 1 cycle later.
- Arming (ARM_FRAMES=4): arm_req, then 3 esc ticks -> still ARMING; 4th tick -> armed=1, duty1=12000.
- Slew ramp:
  - ARMED, ESC cmd 15000 -> duty1 goes 12600, 13200, ..., 15000 over 5 ticks, then holds.
  - Cmd 14700 -> one tick lands exactly on 14700.
- Watchdog (WDOG_FRAMES=3):
  - In ARMED at duty1=15000, no commands for 3 esc ticks -> failsafe=1.
  - Next cycle duty1=12000, duty0=duty2=18000.
  - arm_req is ignored; disarm_req -> DISARMED.
- Priority: arm_req and disarm_req in the same cycle from DISARMED -> stays DISARMED.
  - ESC cmd while DISARMED -> duty1 remains 12000 after the arming sequence.
